spi_slave: RTL

SPI slave endpoint: the stage directly downstream of `spi_master`. It receives `SCLK`, `MOSI` and `CS` from the master, returns data on `MISO`, and exchanges parallel words with local logic. `rx_data`/`rx_valid` carry received words; a one-word transmit holding register has a `tx_load`/`tx_ready` handshake. All pins are oversampled in the single system clock domain. CPOL/CPHA are parameters so the block pairs with any master mode.

---
 rtl/spi_slave.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/MOSI/CS in the system clock domain, shifts words
// MSB first in any CPOL/CPHA mode and exchanges parallel words through a one-word holding register.
module spi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  CS,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  underrun
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_CS_HIGH,
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_next;

    // [0] and [1] form the synchronizer, [2] is the edge-detect history
    logic [2:0] sclk_sync;
    logic [2:0] mosi_sync;
    logic [2:0] cs_sync;

    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  hold_full;
    logic                  under_pend;
    logic                  word_done;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, launch_edge;
    logic cs_s, cs_fall, mosi_s;
    logic frame_start, frame_end;
    logic sample_en, launch_en, word_last, load_evt, accept;

    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[1:0], SCLK};
        mosi_sync <= {mosi_sync[1:0], MOSI};
        cs_sync   <= {cs_sync[1:0], CS};
    end

    assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign launch_edge = CPHA ? lead_edge : trail_edge;
    assign cs_s        = cs_sync[1];
    assign cs_fall     = ~cs_sync[1] & cs_sync[2];
    assign mosi_s      = mosi_sync[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= WAIT_CS_HIGH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            WAIT_CS_HIGH: begin
                if (cs_s) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = WAIT_CS_HIGH;
        endcase
    end

    assign sample_en = (state == ACTIVE) && !cs_s && sample_edge;
    assign launch_en = (state == ACTIVE) && !cs_s && launch_edge;
    assign word_last = sample_en && (bit_cnt == LAST_BIT);
    assign load_evt  = frame_start || word_last;
    assign accept    = tx_load && !hold_full;

    assign busy     = (state == ACTIVE);
    assign tx_ready = !hold_full;

    always_ff @(posedge clk) begin
        if (sample_en) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        end
        if (accept && !load_evt) begin
            hold_reg <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt    <= '0;
            tx_shift   <= '0;
            hold_full  <= 1'b0;
            under_pend <= 1'b0;
            rx_data    <= '0;
            word_done  <= 1'b0;
            rx_valid   <= 1'b0;
            underrun   <= 1'b0;
            MISO       <= 1'b0;
        end else begin
            word_done <= word_last;
            rx_valid  <= word_done;
            underrun  <= 1'b0;
            MISO      <= busy ? tx_shift[DATA_WIDTH-1] : 1'b0;

            if (frame_end) begin
                bit_cnt    <= '0;
                tx_shift   <= '0;
                under_pend <= 1'b0;
            end else begin
                if (sample_en) begin
                    if (word_last) begin
                        rx_data <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    // An empty reload at word end only counts once the next word really starts
                    if (under_pend && (bit_cnt == '0)) begin
                        underrun   <= 1'b1;
                        under_pend <= 1'b0;
                    end
                end

                if (launch_en && (bit_cnt != '0)) begin
                    tx_shift <= tx_shift << 1;
                end

                if (load_evt) begin
                    if (hold_full) begin
                        tx_shift <= hold_reg;
                    end else if (tx_load) begin
                        tx_shift <= tx_data;
                    end else begin
                        tx_shift <= '0;
                        if (frame_start) begin
                            underrun <= 1'b1;
                        end else begin
                            under_pend <= 1'b1;
                        end
                    end
                end
            end

            if (load_evt && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept && !load_evt) begin
                hold_full <= 1'b1;
            end
        end
    end

endmodule
